dbg_scan_master: RTL and testbench

Initiator side of the CPU debug bus. It accepts a scan command (base address, word count), drives `chk_addr` sequentially, and waits a programmable settle time after each address change. It then captures `chk_data` and streams `{address, data}` beats out through a valid/ready port. It sits between the debug responder (CPU info mux, RF, and DM read ports) and a host-facing consumer such as a UART transmitter or a display driver.

---
 rtl/dbg_scan_master.sv | 118 +++++++++++
 tb/tb_dbg_scan_master.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_scan_master.sv
// Debug bus scan initiator: walks chk_addr from a base address, waits SETTLE
// cycles per address, and streams {address, data} beats through valid/ready.
module dbg_scan_master #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_base,
  input  logic [15:0] cmd_count,
  input  logic        abort,
  output logic [15:0] chk_addr,
  input  logic [31:0] chk_data,
  input  logic [31:0] chk_pc,
  output logic [31:0] snap_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_addr,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE - 1);

  logic [1:0]  state;
  logic [15:0] remaining;
  logic [3:0]  settle_cnt;

  assign cmd_ready = (state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      remaining  <= '0;
      settle_cnt <= '0;
      chk_addr   <= '0;
      snap_pc    <= '0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // abort is deliberately not consulted here; a command is always taken
          if (cmd_valid) begin
            snap_pc <= chk_pc;
            if (cmd_count == 16'd0) begin
              done <= 1'b1;
            end else begin
              chk_addr   <= cmd_base;
              remaining  <= cmd_count;
              settle_cnt <= SETTLE_RELOAD;
              busy       <= 1'b1;
              state      <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else if (settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end else begin
            out_data  <= chk_data;
            out_addr  <= chk_addr;
            out_last  <= (remaining == 16'd1);
            out_valid <= 1'b1;
            state     <= S_OUT;
          end
        end

        S_OUT: begin
          if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              chk_addr   <= chk_addr + 16'd1;
              remaining  <= remaining - 16'd1;
              settle_cnt <= SETTLE_RELOAD;
              state      <= S_WAIT;
            end
          end
        end

        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_scan_master.sv
// Directed bench for dbg_scan_master: instance a uses SETTLE=1, instance b SETTLE=2.
module tb_dbg_scan_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] pc = 32'h0040_0000;

  always #5 clk = ~clk;
  always @(posedge clk) pc <= pc + 32'd4;

  logic        a_cmd_valid = 1'b0, a_cmd_ready, a_abort = 1'b0, a_out_ready = 1'b0;
  logic [15:0] a_cmd_base = '0, a_cmd_count = '0, a_chk_addr, a_out_addr;
  logic [31:0] a_chk_data, a_snap_pc, a_out_data;
  logic        a_out_valid, a_out_last, a_busy, a_done;

  logic        b_cmd_valid = 1'b0, b_cmd_ready, b_abort = 1'b0, b_out_ready = 1'b0;
  logic [15:0] b_cmd_base = '0, b_cmd_count = '0, b_chk_addr, b_out_addr;
  logic [31:0] b_chk_data, b_snap_pc, b_out_data;
  logic        b_out_valid, b_out_last, b_busy, b_done;

  // responder model: data = address * 0x1111
  assign a_chk_data = 32'(a_chk_addr) * 32'h1111;
  assign b_chk_data = 32'(b_chk_addr) * 32'h1111;

  dbg_scan_master #(.SETTLE(1)) dut_a (
    .clk(clk), .rst(rst), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_base(a_cmd_base), .cmd_count(a_cmd_count), .abort(a_abort),
    .chk_addr(a_chk_addr), .chk_data(a_chk_data), .chk_pc(pc), .snap_pc(a_snap_pc),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_addr(a_out_addr),
    .out_data(a_out_data), .out_last(a_out_last), .busy(a_busy), .done(a_done)
  );

  dbg_scan_master #(.SETTLE(2)) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_base(b_cmd_base), .cmd_count(b_cmd_count), .abort(b_abort),
    .chk_addr(b_chk_addr), .chk_data(b_chk_data), .chk_pc(pc), .snap_pc(b_snap_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_addr(b_out_addr),
    .out_data(b_out_data), .out_last(b_out_last), .busy(b_busy), .done(b_done)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] bt_addr [16];
  logic [31:0] bt_data [16];
  logic        bt_last [16];
  int          bt_cyc  [16];
  int          nbeats, done_cyc, snap_err;
  logic        rdy_at_done;
  logic [31:0] exp_pc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a command on instance a with out_ready high and records beats
  // (cycle offset relative to the accept edge) until done or the bound.
  task automatic run_scan_a(input logic [15:0] base, input logic [15:0] count, input int bound);
    a_cmd_base  = base;
    a_cmd_count = count;
    a_cmd_valid = 1'b1;
    a_out_ready = 1'b1;
    exp_pc      = pc;
    tick();
    a_cmd_valid = 1'b0;
    a_abort     = 1'b0;
    nbeats = 0; done_cyc = -1; snap_err = 0; rdy_at_done = 1'b0;
    for (int c = 1; c <= bound; c++) begin
      tick();
      if (a_snap_pc !== exp_pc) snap_err++;
      if (a_out_valid === 1'b1 && nbeats < 16) begin
        bt_addr[nbeats] = a_out_addr;
        bt_data[nbeats] = a_out_data;
        bt_last[nbeats] = a_out_last;
        bt_cyc[nbeats]  = c;
        nbeats++;
      end
      if (a_done === 1'b1) begin
        done_cyc    = c;
        rdy_at_done = a_cmd_ready;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    vectors++;
    if ({a_cmd_ready, a_busy, a_done, a_out_valid, a_out_last} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 10000", {a_cmd_ready, a_busy, a_done, a_out_valid, a_out_last});
    end
    vectors++;
    if ({a_chk_addr, a_snap_pc, a_out_addr, a_out_data} !== 96'd0) begin
      miscompares++;
      $display("FAIL reset_regs: addr %h snap %h oaddr %h odata %h expected all zero",
               a_chk_addr, a_snap_pc, a_out_addr, a_out_data);
    end
    #3 rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] ea [3] = '{16'h0000, 16'h0001, 16'h0002};
    logic [31:0] ed [3] = '{32'h0000_0000, 32'h0000_1111, 32'h0000_2222};
    int          ec [3] = '{1, 3, 5};
    run_scan_a(16'h0000, 16'd3, 20);
    vectors++;
    if (nbeats !== 3) begin miscompares++; $display("FAIL basic_nbeats: got %0d expected 3", nbeats); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bt_addr[i] !== ea[i] || bt_data[i] !== ed[i] || bt_last[i] !== (i == 2) || bt_cyc[i] !== ec[i]) begin
        miscompares++;
        $display("FAIL basic_beat%0d: got addr %h data %h last %b cyc %0d expected %h %h %b %0d",
                 i, bt_addr[i], bt_data[i], bt_last[i], bt_cyc[i], ea[i], ed[i], (i == 2), ec[i]);
      end
    end
    vectors++;
    if (done_cyc !== 6 || rdy_at_done !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_done: got cyc %0d ready %b expected 6 1", done_cyc, rdy_at_done);
    end
    tick();
    vectors++;
    if (a_done !== 1'b0) begin miscompares++; $display("FAIL basic_done_width: got %b expected 0", a_done); end
  endtask

  task automatic test_backpressure();
    int first_cyc = -1;
    int hold_err  = 0;
    b_cmd_base  = 16'h1000;
    b_cmd_count = 16'd2;
    b_out_ready = 1'b0;
    b_cmd_valid = 1'b1;
    tick();
    b_cmd_valid = 1'b0;
    for (int c = 1; c <= 8 && first_cyc < 0; c++) begin
      tick();
      if (b_out_valid === 1'b1) first_cyc = c;
    end
    vectors++;
    if (first_cyc !== 2) begin miscompares++; $display("FAIL bp_first_valid: got %0d expected 2", first_cyc); end
    for (int i = 0; i < 5; i++) begin
      if (b_out_valid !== 1'b1 || b_out_addr !== 16'h1000 || b_out_data !== 32'h0111_1000 ||
          b_out_last !== 1'b0 || b_chk_addr !== 16'h1000) hold_err++;
      tick();
    end
    vectors++;
    if (hold_err !== 0) begin miscompares++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", hold_err); end
    b_out_ready = 1'b1;
    tick();
    vectors++;
    if (b_out_valid !== 1'b0 || b_chk_addr !== 16'h1001) begin
      miscompares++;
      $display("FAIL bp_handshake: got valid %b addr %h expected 0 1001", b_out_valid, b_chk_addr);
    end
    tick();
    vectors++;
    if (b_out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_gap: got %b expected 0", b_out_valid); end
    tick();
    vectors++;
    if (b_out_valid !== 1'b1 || b_out_addr !== 16'h1001 || b_out_data !== 32'h0111_2111 || b_out_last !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_beat1: got valid %b addr %h data %h last %b expected 1 1001 01112111 1",
               b_out_valid, b_out_addr, b_out_data, b_out_last);
    end
    tick();
    vectors++;
    if (b_done !== 1'b1 || b_out_valid !== 1'b0 || b_cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_done: got done %b valid %b ready %b expected 1 0 1", b_done, b_out_valid, b_cmd_ready);
    end
    b_out_ready = 1'b0;
  endtask

  task automatic test_wrap_empty();
    run_scan_a(16'hFFFF, 16'd2, 20);
    vectors++;
    if (nbeats !== 2 || bt_addr[0] !== 16'hFFFF || bt_data[0] !== 32'h1110_EEEF || bt_last[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_beat0: got n %0d addr %h data %h last %b expected 2 ffff 1110eeef 0",
               nbeats, bt_addr[0], bt_data[0], bt_last[0]);
    end
    vectors++;
    if (bt_addr[1] !== 16'h0000 || bt_data[1] !== 32'h0 || bt_last[1] !== 1'b1 || done_cyc !== 4) begin
      miscompares++;
      $display("FAIL wrap_beat1: got addr %h data %h last %b done %0d expected 0000 0 1 4",
               bt_addr[1], bt_data[1], bt_last[1], done_cyc);
    end
    tick();
    a_cmd_base  = 16'h1234;
    a_cmd_count = 16'd0;
    a_cmd_valid = 1'b1;
    tick();
    a_cmd_valid = 1'b0;
    vectors++;
    if (a_done !== 1'b1 || a_cmd_ready !== 1'b1 || a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_chk_addr !== 16'h0000) begin
      miscompares++;
      $display("FAIL empty_accept: got done %b ready %b busy %b valid %b addr %h expected 1 1 0 0 0000",
               a_done, a_cmd_ready, a_busy, a_out_valid, a_chk_addr);
    end
    tick();
    vectors++;
    if (a_done !== 1'b0 || a_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_after: got done %b valid %b expected 0 0", a_done, a_out_valid);
    end
  endtask

  task automatic test_abort();
    int nb = 0, bad = 0;
    a_cmd_base  = 16'h0100;
    a_cmd_count = 16'd10;
    a_out_ready = 1'b1;
    a_cmd_valid = 1'b1;
    tick();
    a_cmd_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (a_out_valid === 1'b1) nb++;
    end
    vectors++;
    if (nb !== 4 || a_chk_addr !== 16'h0104 || a_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_pre: got beats %0d addr %h valid %b expected 4 0104 0", nb, a_chk_addr, a_out_valid);
    end
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    vectors++;
    if ({a_out_valid, a_out_last, a_busy, a_done, a_cmd_ready} !== 5'b00001) begin
      miscompares++;
      $display("FAIL abort_state: got %b expected 00001", {a_out_valid, a_out_last, a_busy, a_done, a_cmd_ready});
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (a_out_valid !== 1'b0 || a_done !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin miscompares++; $display("FAIL abort_quiet: got %0d active cycles expected 0", bad); end
    a_abort = 1'b1;
    run_scan_a(16'h0200, 16'd1, 10);
    vectors++;
    if (nbeats !== 1 || bt_addr[0] !== 16'h0200 || bt_data[0] !== 32'h0022_2200 || bt_last[0] !== 1'b1 || done_cyc !== 2) begin
      miscompares++;
      $display("FAIL abort_recmd: got n %0d addr %h data %h last %b done %0d expected 1 0200 00222200 1 2",
               nbeats, bt_addr[0], bt_data[0], bt_last[0], done_cyc);
    end
  endtask

  task automatic test_pc_snap();
    int drift = 0;
    run_scan_a(16'h0010, 16'd2, 20);
    vectors++;
    if (snap_err !== 0 || a_snap_pc !== exp_pc) begin
      miscompares++;
      $display("FAIL snap_during: got snap %h errs %0d expected %h 0", a_snap_pc, snap_err, exp_pc);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (a_snap_pc !== exp_pc) drift++;
    end
    vectors++;
    if (drift !== 0 || pc === exp_pc) begin
      miscompares++;
      $display("FAIL snap_hold: got drift %0d pc %h expected 0 with pc moved from %h", drift, pc, exp_pc);
    end
  endtask

  task automatic test_reset_midscan();
    int bad = 0;
    a_cmd_base  = 16'h0300;
    a_cmd_count = 16'd4;
    a_out_ready = 1'b0;
    a_cmd_valid = 1'b1;
    tick();
    a_cmd_valid = 1'b0;
    tick();
    vectors++;
    if (a_out_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre: got valid %b expected 1", a_out_valid); end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({a_cmd_ready, a_busy, a_done, a_out_valid, a_out_last} !== 5'b10000 ||
        {a_chk_addr, a_snap_pc, a_out_addr, a_out_data} !== 96'd0) begin
      miscompares++;
      $display("FAIL rstmid_async: got flags %b addr %h snap %h oaddr %h odata %h expected 10000 and zeros",
               {a_cmd_ready, a_busy, a_done, a_out_valid, a_out_last}, a_chk_addr, a_snap_pc, a_out_addr, a_out_data);
    end
    tick();
    tick();
    #3 rst = 1'b0;
    a_out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (a_out_valid !== 1'b0 || a_done !== 1'b0 || a_busy !== 1'b0 || a_snap_pc !== 32'd0) bad++;
    end
    vectors++;
    if (bad !== 0) begin miscompares++; $display("FAIL rstmid_after: got %0d active cycles expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap_empty();
    test_abort();
    test_pc_snap();
    test_reset_midscan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
